// File: rtl/pg_carry_pipe.sv
// pg_carry_pipe: two-stage propagate/generate + 4-bit-group carry-lookahead pipeline.
// Stage 1 registers p/g/cin. Stage 2 registers the carry vector, cout and ovf.
// Optional subtract mode: define PG_CARRY_SUB_EN to add the 'sub' input (a - b).
module pg_carry_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PG_CARRY_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] c_out,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NG = WIDTH / GROUP;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic             s1_cin;

  logic             s1_load;
  logic             s2_load;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic [WIDTH-1:0] c_n;
  logic             cout_n;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

`ifdef PG_CARRY_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_cin   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p   <= a ^ b_eff;
        s1_g   <= a & b_eff;
        s1_cin <= cin_eff;
      end
    end
  end

  // Group carries ripple group-to-group through a scalar; bit carries inside
  // a group are written out in flattened lookahead form so no vector feeds itself.
  always_comb begin
    logic       carry;
    logic       gp;
    logic       gg;
    logic [3:0] p4;
    logic [3:0] g4;
    c_n   = '0;
    carry = s1_cin;
    gp    = 1'b0;
    gg    = 1'b0;
    p4    = '0;
    g4    = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      p4 = s1_p[4*k +: 4];
      g4 = s1_g[4*k +: 4];
      gp = &p4;
      gg = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) | (p4[3] & p4[2] & p4[1] & g4[0]);
      c_n[4*k]   = carry;
      c_n[4*k+1] = g4[0] | (p4[0] & carry);
      c_n[4*k+2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & carry);
      c_n[4*k+3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) | (p4[2] & p4[1] & p4[0] & carry);
      carry      = gg | (gp & carry);
    end
    cout_n = carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      p_out     <= '0;
      c_out     <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        p_out <= s1_p;
        c_out <= c_n;
        cout  <= cout_n;
        ovf   <= c_n[WIDTH-1] ^ cout_n;
      end
    end
  end

endmodule

// File: doc/pg_carry_pipe.md
Name: pg_carry_pipe

Overview:
- Two-stage pipelined propagate/generate and carry-lookahead unit for the ALU adder path.
- Sits directly upstream of the per-bit sigma (sum) cells: it produces the per-bit propagate vector and the carry-into-bit vector.
- The downstream cells form each sum bit as sum[i] = p[i] XOR c[i].
- Uses a valid/ready handshake with full stall propagation, so it can sit in a back-pressured datapath.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of 4 and at least 4.
- GROUP, 4: lookahead group size in bits. Fixed at 4; the parameter exists for documentation only.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage 1 can accept a beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- p_out  output  WIDTH  propagate vector, a XOR b (B after inversion when the optional feature is active).
- c_out  output  WIDTH  carry into each bit. c_out[0] = cin.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow, c[WIDTH-1] XOR cout.

Behaviour:
- Reset (asynchronous, any time, including mid-stream): all pipeline valid flags clear. out_valid=0, p_out=0, c_out=0, cout=0, ovf=0. in_ready=1 one cycle after rst deasserts. In-flight beats are discarded.
- Stage 1 (S1) register captures p = a^b, g = a&b and cin on in_valid && in_ready.
- Stage 2 (S2) register captures from S1:
  - 4-bit group propagate PG = &p[grp] and group generate GG.
  - Group carries: C[k+1] = GG[k] | PG[k]&C[k], with C[0] = S1 cin.
  - Ripple inside each group.
  - Full c vector, cout, ovf and the p vector are registered.
- Latency: exactly 2 cycles from input acceptance to out_valid with no stall.
- Throughput: 1 beat per cycle.
- Stall rules:
  - S2 loads when !s2_valid || out_ready.
  - S1 loads when !s1_valid || S2 loads.
  - in_ready = !s1_valid || S2 loads. This is combinational from out_ready; no skid buffer.
- Outputs hold stable while out_valid && !out_ready. A beat is never dropped or duplicated.
- Simultaneous events:
  - Accept and drain in the same cycle is allowed in each stage.
  - in_valid with in_ready=0 is ignored. The source must hold the beat.
- Bubble: if S1 is empty when S2 loads, s2_valid clears and the data registers keep their old value.
- Wrap-around: the carry out of the MSB goes to cout only. There is no wrap into bit 0.
- Arithmetic: p_out ^ c_out equals (a + b + cin) mod 2^WIDTH. {cout, sum} is the full WIDTH+1-bit result.

Optional Feature:
- Macro: PG_CARRY_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - When sub=1, stage 1 uses ~b and forces the effective cin to 1, so the result is a - b.
  - cout=1 means no borrow. ovf keeps its signed meaning.
- When undefined: no sub port, and b and cin are used as-is.

Test Plan:
- Reset: assert rst mid-stream with two beats in flight -> out_valid=0 and all outputs 0 immediately; no stale beat emerges after release.
- Add, WIDTH=16: a=0x00FF, b=0x0001, cin=0 -> 2 cycles later p_out=0x00FE, c_out=0x01FE, cout=0, ovf=0 (sum 0x0100).
- Wrap: a=0xFFFF, b=0x0001, cin=0 -> p_out=0xFFFE, c_out=0xFFFE, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 -> cout=0, ovf=1.
- Back-pressure: stream beats 1..4 back to back with out_ready=0 for cycles 3-6 -> in_ready drops after 2 beats are held; results for beats 1..4 emerge in order, each exactly once, values unchanged while stalled.
- Bubbles and full rate: alternate in_valid 1/0, then continuous valid with out_ready=1 -> one result per accepted beat at a fixed 2-cycle latency; out_valid gaps match the input gaps.
- With PG_CARRY_SUB_EN: a=0x0005, b=0x0007, sub=1 -> p_out^c_out=0xFFFE, cout=0. Also a=0x8000, b=0x0001, sub=1 -> sum 0x7FFF, ovf=1.
